// File: rtl/neokeon_core_param_if.sv
// Host-side handshake bundle for the parametrised Neokeon core.
// The master drives the key/data strobes and the slave returns the result, valid and busy flags.
interface neokeon_core_param_if;
    logic [127:0] inKey;
    logic         inKeyWr;
    logic [127:0] inData;
    logic         inDataWr;
    logic         inDecrypt;
    logic [127:0] outData;
    logic         outValid;
    logic         outBusy;

    modport master (
        output inKey, inKeyWr, inData, inDataWr, inDecrypt,
        input  outData, outValid, outBusy
    );

    modport slave (
        input  inKey, inKeyWr, inData, inDataWr, inDecrypt,
        output outData, outValid, outBusy
    );
endinterface

// File: rtl/neokeon_core_param.sv
// Parametrised Neokeon block cipher core (encrypt/decrypt, direct or indirect key).
// It has an unrolled round datapath of ROUNDS_PER_CYCLE rounds, and it processes one block at a time.
module neokeon_core_param #(
    parameter int ROUNDS           = 16,
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter bit INDIRECT_KEY     = 1'b0
) (
    input  logic                inClk,
    input  logic                inRst,
    neokeon_core_param_if.slave bus
);
    localparam int N  = ROUNDS / ROUNDS_PER_CYCLE;
    localparam int CW = $clog2(N + 2);
    localparam logic [CW-1:0] LAST_RUN  = CW'(N - 1);
    localparam logic [CW-1:0] KEY_FINAL = CW'(N);

    typedef enum logic [2:0] {IDLE, KSCHED, DKEY, RUN, FINAL} stateT;

    // Round-constant LFSR, forward and inverse steps
    function automatic logic [7:0] rconFwd(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] rconRev(input logic [7:0] r);
        logic [7:0] t;
        t = r ^ (r[0] ? 8'h1B : 8'h00);
        return {r[0], t[7:1]};
    endfunction

    function automatic logic [7:0] rconAt(input int idx);
        logic [7:0] r;
        r = 8'h80;
        for (int i = 0; i < idx; i++) r = rconFwd(r);
        return r;
    endfunction

    // Decryption starts from the constant that encryption would end on
    localparam logic [7:0] RCON_LAST = rconAt(ROUNDS);

    function automatic logic [127:0] rcWord(input logic [7:0] rc);
        return {24'h0, rc, 96'h0};
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] theta(input logic [127:0] s, input logic [127:0] k);
        logic [31:0] a0, a1, a2, a3, t;
        a0 = s[127:96]; a1 = s[95:64]; a2 = s[63:32]; a3 = s[31:0];
        t  = a0 ^ a2;
        t  = t ^ rotl(t, 8) ^ rotl(t, 24);
        a1 = a1 ^ t;
        a3 = a3 ^ t;
        a0 = a0 ^ k[127:96];
        a1 = a1 ^ k[95:64];
        a2 = a2 ^ k[63:32];
        a3 = a3 ^ k[31:0];
        t  = a1 ^ a3;
        t  = t ^ rotl(t, 8) ^ rotl(t, 24);
        a0 = a0 ^ t;
        a2 = a2 ^ t;
        return {a0, a1, a2, a3};
    endfunction

    function automatic logic [127:0] gamma(input logic [127:0] s);
        logic [31:0] a0, a1, a2, a3, t;
        a0 = s[127:96]; a1 = s[95:64]; a2 = s[63:32]; a3 = s[31:0];
        a1 = a1 ^ (~a3 & ~a2);
        a0 = a0 ^ (a2 & a1);
        t  = a3;
        a3 = a0;
        a0 = t;
        a2 = a2 ^ a0 ^ a1 ^ a3;
        a1 = a1 ^ (~a3 & ~a2);
        a0 = a0 ^ (a2 & a1);
        return {a0, a1, a2, a3};
    endfunction

    function automatic logic [127:0] pi1(input logic [127:0] s);
        return {s[127:96], rotl(s[95:64], 1), rotl(s[63:32], 5), rotl(s[31:0], 2)};
    endfunction

    function automatic logic [127:0] pi2(input logic [127:0] s);
        return {s[127:96], rotl(s[95:64], 31), rotl(s[63:32], 27), rotl(s[31:0], 30)};
    endfunction

    // Decryption swaps the order of the key mix and the constant injection
    function automatic logic [127:0] neoRound(input logic [127:0] s, input logic [127:0] k,
                                              input logic [7:0] rc, input logic dec);
        logic [127:0] x;
        if (dec) x = theta(s, k) ^ rcWord(rc);
        else     x = theta(s ^ rcWord(rc), k);
        return pi2(gamma(pi1(x)));
    endfunction

    stateT        fsmReg;
    logic [CW-1:0] cntReg;
    logic [127:0] stateReg;
    logic [127:0] dataReg;
    logic         decReg;
    logic         pendingReg;
    logic [7:0]   rconReg;
    logic [127:0] wkReg;
    logic [127:0] dkReg;
    logic [127:0] outDataReg;
    logic         outValidReg;
    logic         outBusyReg;

    logic         decMode;
    logic [127:0] roundKey;
    logic [127:0] roundOut;
    logic [7:0]   roundRcon;
    logic [127:0] finalOut;

    // Key schedule always runs encryption under the all-zero key
    assign decMode  = decReg && (fsmReg == RUN || fsmReg == FINAL);
    assign roundKey = (fsmReg == KSCHED) ? 128'h0 : (decReg ? dkReg : wkReg);

    genvar gi;
    generate
        for (gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : gRound
            logic [127:0] sIn;
            logic [127:0] sOut;
            logic [7:0]   rIn;
            logic [7:0]   rOut;
            if (gi == 0) begin : gFirst
                assign sIn = stateReg;
                assign rIn = rconReg;
            end else begin : gNext
                assign sIn = gRound[gi-1].sOut;
                assign rIn = gRound[gi-1].rOut;
            end
            assign sOut = neoRound(sIn, roundKey, rIn, decMode);
            assign rOut = decMode ? rconRev(rIn) : rconFwd(rIn);
        end
    endgenerate

    assign roundOut  = gRound[ROUNDS_PER_CYCLE-1].sOut;
    assign roundRcon = gRound[ROUNDS_PER_CYCLE-1].rOut;

    // Output whitening step; the decrypt side is also the tail of every decrypt round
    always_comb begin
        finalOut = '0;
        if (decMode) finalOut = theta(stateReg, roundKey) ^ rcWord(rconReg);
        else         finalOut = theta(stateReg ^ rcWord(rconReg), roundKey);
    end

    // Control FSM, key registers, round state and registered outputs
    always_ff @(posedge inClk) begin
        if (inRst) begin
            fsmReg      <= IDLE;
            cntReg      <= '0;
            stateReg    <= '0;
            dataReg     <= '0;
            decReg      <= 1'b0;
            pendingReg  <= 1'b0;
            rconReg     <= 8'h80;
            wkReg       <= '0;
            dkReg       <= '0;
            outDataReg  <= '0;
            outValidReg <= 1'b0;
            outBusyReg  <= 1'b0;
        end else begin
            outValidReg <= 1'b0;
            case (fsmReg)
                IDLE: begin
                    if (bus.inKeyWr) begin
                        outBusyReg <= 1'b1;
                        if (INDIRECT_KEY) begin
                            stateReg <= bus.inKey;
                            rconReg  <= 8'h80;
                            cntReg   <= '0;
                            fsmReg   <= KSCHED;
                        end else begin
                            wkReg  <= bus.inKey;
                            fsmReg <= DKEY;
                        end
                        if (bus.inDataWr) begin
                            dataReg    <= bus.inData;
                            decReg     <= bus.inDecrypt;
                            pendingReg <= 1'b1;
                        end
                    end else if (bus.inDataWr) begin
                        outBusyReg <= 1'b1;
                        stateReg   <= bus.inData;
                        decReg     <= bus.inDecrypt;
                        rconReg    <= bus.inDecrypt ? RCON_LAST : 8'h80;
                        cntReg     <= '0;
                        fsmReg     <= RUN;
                    end
                end
                KSCHED: begin
                    if (cntReg == KEY_FINAL) begin
                        wkReg  <= finalOut;
                        fsmReg <= DKEY;
                    end else begin
                        stateReg <= roundOut;
                        rconReg  <= roundRcon;
                        cntReg   <= cntReg + 1'b1;
                    end
                end
                DKEY: begin
                    dkReg <= theta(wkReg, 128'h0);
                    if (pendingReg) begin
                        pendingReg <= 1'b0;
                        stateReg   <= dataReg;
                        rconReg    <= decReg ? RCON_LAST : 8'h80;
                        cntReg     <= '0;
                        fsmReg     <= RUN;
                    end else begin
                        outBusyReg <= 1'b0;
                        fsmReg     <= IDLE;
                    end
                end
                RUN: begin
                    stateReg <= roundOut;
                    rconReg  <= roundRcon;
                    if (cntReg == LAST_RUN) fsmReg <= FINAL;
                    else                    cntReg <= cntReg + 1'b1;
                end
                FINAL: begin
                    outDataReg  <= finalOut;
                    outValidReg <= 1'b1;
                    outBusyReg  <= 1'b0;
                    fsmReg      <= IDLE;
                end
                default: fsmReg <= IDLE;
            endcase
        end
    end

    assign bus.outData  = outDataReg;
    assign bus.outValid = outValidReg;
    assign bus.outBusy  = outBusyReg;
endmodule

// File: tb/tb_neokeon_core_param.sv
// Self-checking bench for neokeon_core_param.
// It covers known-answer vectors, unrolled variants, indirect key mode, busy strobes and mid-operation reset.
module tb_neokeon_core_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [127:0] sbQ[$];

    localparam logic [127:0] K1    = 128'hb1656851699e29fa24b70148503d2dfc;
    localparam logic [127:0] D1    = 128'h2a78421b87c7d0924f26113f1d1349b2;
    localparam logic [127:0] E1    = 128'he2f687e07b75660ffc372233bc47532c;
    localparam logic [127:0] ONES  = {128{1'b1}};
    localparam logic [16:0][7:0] RC_TAB = {8'hD4, 8'h6A, 8'h35, 8'h97, 8'hC6, 8'h63, 8'hBC, 8'h5E,
                                           8'h2F, 8'h9A, 8'h4D, 8'hAB, 8'hD8, 8'h6C, 8'h36, 8'h1B, 8'h80};

    always #5 clk = ~clk;

    neokeon_core_param_if busMain();
    neokeon_core_param_if busR4();
    neokeon_core_param_if busR16();
    neokeon_core_param_if busInd();

    neokeon_core_param #(.ROUNDS(16), .ROUNDS_PER_CYCLE(1), .INDIRECT_KEY(1'b0))
        dutMain (.inClk(clk), .inRst(rst), .bus(busMain));
    neokeon_core_param #(.ROUNDS(16), .ROUNDS_PER_CYCLE(4), .INDIRECT_KEY(1'b0))
        dutR4 (.inClk(clk), .inRst(rst), .bus(busR4));
    neokeon_core_param #(.ROUNDS(16), .ROUNDS_PER_CYCLE(16), .INDIRECT_KEY(1'b0))
        dutR16 (.inClk(clk), .inRst(rst), .bus(busR16));
    neokeon_core_param #(.ROUNDS(16), .ROUNDS_PER_CYCLE(2), .INDIRECT_KEY(1'b1))
        dutInd (.inClk(clk), .inRst(rst), .bus(busInd));

    // ---------------- reference model ----------------
    function automatic logic [31:0] mRotl(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} << n;
        return d[63:32];
    endfunction

    function automatic logic [127:0] mTheta(input logic [127:0] s, input logic [127:0] k);
        logic [31:0] a[4];
        logic [31:0] kk[4];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) begin
            a[i]  = s[127-32*i -: 32];
            kk[i] = k[127-32*i -: 32];
        end
        t = a[0] ^ a[2];
        t = t ^ mRotl(t, 8) ^ mRotl(t, 24);
        a[1] = a[1] ^ t;
        a[3] = a[3] ^ t;
        for (int i = 0; i < 4; i++) a[i] = a[i] ^ kk[i];
        t = a[1] ^ a[3];
        t = t ^ mRotl(t, 8) ^ mRotl(t, 24);
        a[0] = a[0] ^ t;
        a[2] = a[2] ^ t;
        return {a[0], a[1], a[2], a[3]};
    endfunction

    // Pi1, Gamma, Pi2 in sequence
    function automatic logic [127:0] mPgp(input logic [127:0] s);
        logic [31:0] a[4];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) a[i] = s[127-32*i -: 32];
        a[1] = mRotl(a[1], 1); a[2] = mRotl(a[2], 5); a[3] = mRotl(a[3], 2);
        a[1] = a[1] ^ (~a[3] & ~a[2]);
        a[0] = a[0] ^ (a[2] & a[1]);
        t = a[3]; a[3] = a[0]; a[0] = t;
        a[2] = a[2] ^ a[0] ^ a[1] ^ a[3];
        a[1] = a[1] ^ (~a[3] & ~a[2]);
        a[0] = a[0] ^ (a[2] & a[1]);
        a[1] = mRotl(a[1], 31); a[2] = mRotl(a[2], 27); a[3] = mRotl(a[3], 30);
        return {a[0], a[1], a[2], a[3]};
    endfunction

    function automatic logic [127:0] mEncrypt(input logic [127:0] k, input logic [127:0] p);
        logic [127:0] s;
        s = p;
        for (int r = 0; r < 16; r++) begin
            s[103:96] = s[103:96] ^ RC_TAB[r];
            s = mPgp(mTheta(s, k));
        end
        s[103:96] = s[103:96] ^ RC_TAB[16];
        return mTheta(s, k);
    endfunction

    function automatic logic [127:0] mDecrypt(input logic [127:0] k, input logic [127:0] c);
        logic [127:0] s;
        logic [127:0] dk;
        dk = mTheta(k, 128'h0);
        s  = c;
        for (int r = 16; r >= 1; r--) begin
            s = mTheta(s, dk);
            s[103:96] = s[103:96] ^ RC_TAB[r];
            s = mPgp(s);
        end
        s = mTheta(s, dk);
        s[103:96] = s[103:96] ^ RC_TAB[0];
        return s;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- access helpers (no checking) ----------------
    function automatic logic vOf(input int sel);
        case (sel)
            0: return busMain.outValid;
            1: return busR4.outValid;
            2: return busR16.outValid;
            default: return busInd.outValid;
        endcase
    endfunction

    function automatic logic bOf(input int sel);
        case (sel)
            0: return busMain.outBusy;
            1: return busR4.outBusy;
            2: return busR16.outBusy;
            default: return busInd.outBusy;
        endcase
    endfunction

    function automatic logic [127:0] dOf(input int sel);
        case (sel)
            0: return busMain.outData;
            1: return busR4.outData;
            2: return busR16.outData;
            default: return busInd.outData;
        endcase
    endfunction

    function automatic int nOf(input int sel);
        case (sel)
            0: return 16;
            1: return 4;
            2: return 1;
            default: return 8;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setIn(input int sel, input logic [127:0] k, input bit kw,
                         input logic [127:0] d, input bit dw, input bit dec);
        case (sel)
            0: begin busMain.inKey = k; busMain.inKeyWr = kw; busMain.inData = d;
                     busMain.inDataWr = dw; busMain.inDecrypt = dec; end
            1: begin busR4.inKey = k; busR4.inKeyWr = kw; busR4.inData = d;
                     busR4.inDataWr = dw; busR4.inDecrypt = dec; end
            2: begin busR16.inKey = k; busR16.inKeyWr = kw; busR16.inData = d;
                     busR16.inDataWr = dw; busR16.inDecrypt = dec; end
            default: begin busInd.inKey = k; busInd.inKeyWr = kw; busInd.inData = d;
                     busInd.inDataWr = dw; busInd.inDecrypt = dec; end
        endcase
    endtask

    // Presents the strobes for one edge (the write edge), returns 1 time unit after it
    task automatic driveOp(input int sel, input logic [127:0] k, input bit kw,
                           input logic [127:0] d, input bit dw, input bit dec);
        setIn(sel, k, kw, d, dw, dec);
        tick();
        setIn(sel, k, 1'b0, d, 1'b0, dec);
    endtask

    // Cycles from the write edge to the first observed outValid; -1 on timeout
    task automatic waitValid(input int sel, output int cyc, output bit gap);
        cyc = -1;
        gap = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (vOf(sel)) begin
                cyc = i;
                break;
            end
            if (!bOf(sel)) gap = 1'b1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        for (int s = 0; s < 4; s++) setIn(s, '0, 1'b0, '0, 1'b0, 1'b0);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        for (int s = 0; s < 4; s++) begin
            total++;
            if (dOf(s) !== 128'h0 || vOf(s) !== 1'b0 || bOf(s) !== 1'b0)
                $display("FAIL reset[%0d]: data=%h valid=%b busy=%b, required 0/0/0", s, dOf(s), vOf(s), bOf(s));
            if (dOf(s) !== 128'h0 || vOf(s) !== 1'b0 || bOf(s) !== 1'b0) bad++;
        end
    endtask

    // One complete operation on instance sel through the scoreboard, with a latency check
    task automatic runOp(input string name, input int sel, input logic [127:0] k, input bit kw,
                         input logic [127:0] d, input bit dec, input logic [127:0] exp, input int expCyc);
        int cyc;
        bit gap;
        logic [127:0] want;
        sbQ.push_back(exp);
        driveOp(sel, k, kw, d, 1'b1, dec);
        waitValid(sel, cyc, gap);
        total++;
        if (cyc != expCyc || gap) begin
            bad++;
            $display("FAIL %s latency: cycles=%0d busyGap=%0b, required %0d and no gap", name, cyc, gap, expCyc);
        end
        want = (sbQ.size() > 0) ? sbQ.pop_front() : 128'hx;
        total++;
        if (dOf(sel) !== want) begin
            bad++;
            $display("FAIL %s data: got %h, required %h", name, dOf(sel), want);
        end else begin
            $display("op %s sel=%0d result=%h cycles=%0d", name, sel, dOf(sel), cyc);
        end
        total++;
        if (cyc > 0 && bOf(sel) !== 1'b0) begin
            bad++;
            $display("FAIL %s busyAtValid: got %b, required 0", name, bOf(sel));
        end
        tick();
        total++;
        if (vOf(sel) !== 1'b0 || dOf(sel) !== exp) begin
            bad++;
            $display("FAIL %s pulseWidth: valid=%b data=%h, required 0 and held %h", name, vOf(sel), dOf(sel), exp);
        end
    endtask

    task automatic test_known_vectors();
        int n;
        runOp("zeroKey", 0, 128'h0, 1'b0, 128'h0, 1'b0, K1, 17);
        runOp("sameCycle", 0, K1, 1'b1, D1, 1'b0, E1, 18);
        runOp("decrypt", 0, 128'h0, 1'b0, E1, 1'b1, D1, 17);
        driveOp(0, ONES, 1'b1, 128'h0, 1'b0, 1'b0);
        n = 0;
        for (int i = 0; i < 100 && bOf(0); i++) begin n++; tick(); end
        total++;
        if (n != 1) begin
            bad++;
            $display("FAIL directKeyBusy: got %0d cycles, required 1", n);
        end
        runOp("allOnes", 0, 128'h0, 1'b0, ONES, 1'b0, D1, 17);
    endtask

    task automatic test_busy_ignore();
        int cyc;
        int extra;
        bit gap;
        logic [127:0] p;
        logic [127:0] want;
        p = rnd128();
        sbQ.push_back(mEncrypt(ONES, p));
        driveOp(0, 128'h0, 1'b0, p, 1'b1, 1'b0);
        repeat (3) tick();
        driveOp(0, rnd128(), 1'b1, rnd128(), 1'b1, 1'b1);
        waitValid(0, cyc, gap);
        want = (sbQ.size() > 0) ? sbQ.pop_front() : 128'hx;
        total++;
        if (cyc < 0 || dOf(0) !== want) begin
            bad++;
            $display("FAIL busyIgnore data: got %h cycles=%0d, required %h", dOf(0), cyc, want);
        end
        extra = 0;
        for (int i = 0; i < 25; i++) begin tick(); if (vOf(0)) extra++; end
        total++;
        if (extra != 0) begin
            bad++;
            $display("FAIL busyIgnore extraPulse: got %0d pulses, required 0", extra);
        end
        p = rnd128();
        runOp("keyKept", 0, 128'h0, 1'b0, p, 1'b0, mEncrypt(ONES, p), 17);
    endtask

    task automatic test_random_direct();
        logic [127:0] k;
        logic [127:0] p;
        logic [127:0] c;
        for (int it = 0; it < 3; it++) begin
            k = rnd128();
            p = rnd128();
            c = mEncrypt(k, p);
            runOp("rndEnc", 0, k, 1'b1, p, 1'b0, c, 18);
            runOp("rndDec", 0, 128'h0, 1'b0, c, 1'b1, p, 17);
        end
    endtask

    task automatic test_unroll();
        for (int s = 1; s <= 2; s++) begin
            runOp("unrollZero", s, 128'h0, 1'b0, 128'h0, 1'b0, K1, nOf(s) + 1);
            runOp("unrollSame", s, K1, 1'b1, D1, 1'b0, E1, nOf(s) + 2);
            runOp("unrollDec", s, 128'h0, 1'b0, E1, 1'b1, D1, nOf(s) + 1);
        end
    endtask

    task automatic test_indirect();
        logic [127:0] k;
        logic [127:0] p;
        logic [127:0] wk;
        int n;
        for (int it = 0; it < 3; it++) begin
            k  = rnd128();
            p  = rnd128();
            wk = mEncrypt(128'h0, k);
            driveOp(3, k, 1'b1, 128'h0, 1'b0, 1'b0);
            n = 0;
            for (int i = 0; i < 100 && bOf(3); i++) begin n++; tick(); end
            total++;
            if (n != nOf(3) + 2) begin
                bad++;
                $display("FAIL indirectKeyBusy: got %0d cycles, required %0d", n, nOf(3) + 2);
            end
            runOp("indEnc", 3, 128'h0, 1'b0, p, 1'b0, mEncrypt(wk, p), nOf(3) + 1);
            runOp("indDec", 3, 128'h0, 1'b0, mEncrypt(wk, p), 1'b1, p, nOf(3) + 1);
        end
        k  = rnd128();
        p  = rnd128();
        wk = mEncrypt(128'h0, k);
        runOp("indSame", 3, k, 1'b1, p, 1'b0, mEncrypt(wk, p), 2 * nOf(3) + 3);
    endtask

    task automatic test_reset_mid_run();
        int pulses;
        driveOp(0, 128'h0, 1'b0, rnd128(), 1'b1, 1'b0);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        total++;
        if (bOf(0) !== 1'b0 || vOf(0) !== 1'b0 || dOf(0) !== 128'h0) begin
            bad++;
            $display("FAIL midReset: busy=%b valid=%b data=%h, required 0/0/0", bOf(0), vOf(0), dOf(0));
        end
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin tick(); if (vOf(0)) pulses++; end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL midReset latePulse: got %0d pulses, required 0", pulses);
        end
        runOp("afterReset", 0, 128'h0, 1'b0, 128'h0, 1'b0, K1, 17);
    endtask

    initial begin
        test_reset();
        test_known_vectors();
        test_busy_ignore();
        test_random_direct();
        test_unroll();
        test_indirect();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
